// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW/load-use detection,
// taken-branch squash and multi-cycle MEM-stage freeze with stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             id_valid,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bit         HAS_LAT = (MEM_LATENCY > 0);
  localparam logic [3:0] LAT_M1  = 4'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);

  state_t           state_q;
  logic [3:0]       wait_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic exe_hit1, exe_hit2, mem_hit1, mem_hit2;
  logic raw_full, raw_load_use, raw;
  logic mem_stall;

  // Register-match terms shared by the full-RAW and load-use checks.
  assign exe_hit1 = exe_wb_en & (exe_dest == src1);
  assign exe_hit2 = exe_wb_en & (exe_dest == src2);
  assign mem_hit1 = mem_wb_en & (mem_dest == src1);
  assign mem_hit2 = mem_wb_en & (mem_dest == src2);

  assign raw_full     = id_valid & (exe_hit1 | mem_hit1 | (two_src & (exe_hit2 | mem_hit2)));
  assign raw_load_use = id_valid & exe_mem_read & (exe_hit1 | (two_src & exe_hit2));
  assign raw          = forward_en ? raw_load_use : raw_full;

  assign mem_stall = ((state_q == IDLE) & mem_req & HAS_LAT) | (state_q == WAIT);

  // Priority: memory stall, then taken branch, then RAW; all forced low in reset.
  always_comb begin
    pipe_freeze = 1'b0;
    if_flush    = 1'b0;
    id_bubble   = 1'b0;
    if_freeze   = 1'b0;
    if (!rst) begin
      pipe_freeze = mem_stall;
      if_flush    = branch_taken & ~mem_stall;
      id_bubble   = (branch_taken | raw) & ~mem_stall;
      if_freeze   = mem_stall | (raw & ~branch_taken);
    end
  end

  // wait_q holds the number of WAIT cycles still to come, including the current
  // one; IDLE already accounts for the first stall cycle of an access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req && HAS_LAT) begin
            wait_q  <= LAT_M1;
            state_q <= (LAT_M1 == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (wait_q <= 4'd1) begin
            wait_q  <= 4'd0;
            state_q <= DONE;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (if_freeze && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: driver pushes expected control/counter
// values per cycle, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int W     = 4 + 2 * CNT_W;

  logic             clk;
  logic             rst;
  logic [3:0]       src1, src2, exe_dest, mem_dest;
  logic             two_src, id_valid, exe_wb_en, exe_mem_read;
  logic             mem_wb_en, forward_en, branch_taken, mem_req;
  logic             if_freeze, if_flush, id_bubble, pipe_freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       fsm_state;

  logic [W-1:0]     exp_q[$];
  string            name_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  pipe_hazard_ctrl #(.MEM_LATENCY(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .src1(src1), .src2(src2), .two_src(two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .forward_en(forward_en),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .if_freeze(if_freeze), .if_flush(if_flush), .id_bubble(id_bubble),
    .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic clear_inputs();
    src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; id_valid = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; forward_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0;
  endtask

  // exp_ctl = {if_freeze, if_flush, id_bubble, pipe_freeze} for the current cycle.
  task automatic cycle(input logic [3:0] exp_ctl, input string nm);
    if (rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end
    exp_q.push_back({exp_ctl, exp_stall, exp_flush});
    name_q.push_back(nm);
    if (!rst) begin
      if (exp_ctl[3] && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + 1'b1;
      if (exp_ctl[2] && exp_flush != {CNT_W{1'b1}}) exp_flush = exp_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      logic [3:0]   act_ctl;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act_ctl = {if_freeze, if_flush, id_bubble, pipe_freeze};
      checks++;
      if (act_ctl !== e[W-1 -: 4]) begin
        errors++;
        $display("FAIL %s/ctl: got %b expected %b (freeze,flush,bubble,pfreeze)",
                 nm, act_ctl, e[W-1 -: 4]);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== e[2*CNT_W-1:0]) begin
        errors++;
        $display("FAIL %s/cnt: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 nm, stall_cnt, flush_cnt, e[2*CNT_W-1 -: CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    // Hazard inputs active while in reset: outputs must stay low.
    mem_req = 1'b1; branch_taken = 1'b1; id_valid = 1'b1; exe_wb_en = 1'b1;
    cycle(4'b0000, "reset_outputs");

    rst = 1'b0; clear_inputs();
    cycle(4'b0000, "idle");

    forward_en = 1'b1; exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
    src1 = 4'd3; id_valid = 1'b1;
    cycle(4'b1010, "load_use");
    exe_mem_read = 1'b0;
    cycle(4'b0000, "fwd_alu_no_stall");

    clear_inputs();
    mem_wb_en = 1'b1; mem_dest = 4'd5; two_src = 1'b1; src2 = 4'd5; id_valid = 1'b1;
    cycle(4'b1010, "raw_mem_src2");
    two_src = 1'b0;
    cycle(4'b0000, "raw_src2_unused");
    two_src = 1'b1; id_valid = 1'b0;
    cycle(4'b0000, "raw_id_invalid");

    clear_inputs();
    exe_wb_en = 1'b1; exe_dest = 4'd7; src1 = 4'd7; id_valid = 1'b1;
    cycle(4'b1010, "raw_exe_src1");
    branch_taken = 1'b1;
    cycle(4'b0110, "branch_over_raw");
    clear_inputs();
    branch_taken = 1'b1;
    cycle(4'b0110, "branch_alone");
    clear_inputs();
    cycle(4'b0000, "idle2");

    mem_req = 1'b1;
    cycle(4'b1001, "mem_idle");
    cycle(4'b1001, "mem_wait");
    cycle(4'b0000, "mem_done");
    mem_req = 1'b0;
    cycle(4'b0000, "mem_back_idle");
    mem_req = 1'b1;
    cycle(4'b1001, "mem2_idle");
    cycle(4'b1001, "mem2_wait");
    mem_req = 1'b0;
    cycle(4'b0000, "mem2_done");

    // Branch and RAW arriving during a memory stall.
    mem_req = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd2; src1 = 4'd2; id_valid = 1'b1;
    cycle(4'b1001, "raw_in_mem_stall");
    branch_taken = 1'b1;
    cycle(4'b1001, "branch_in_wait");
    cycle(4'b0110, "branch_in_done");
    clear_inputs();
    cycle(4'b0000, "idle3");

    // Reset in the middle of WAIT.
    mem_req = 1'b1;
    cycle(4'b1001, "pre_reset_idle");
    rst = 1'b1;
    cycle(4'b0000, "reset_mid_wait");
    rst = 1'b0;
    cycle(4'b1001, "restart_idle");
    cycle(4'b1001, "restart_wait");
    cycle(4'b0000, "restart_done");
    mem_req = 1'b0;
    cycle(4'b0000, "final_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
